// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I execute-stage ALU. The package holds the
// operand width, the shift-amount width and the funct3-style operation encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    // RV32I funct3 encoding. The `sign` modifier bit selects between SUB and
    // ADD, and between SRA and SRL.
    typedef enum logic [2:0] {
        ADD_SUB = 3'b000,
        SLL     = 3'b001,
        SLT     = 3'b010,
        SLTU    = 3'b011,
        XOR     = 3'b100,
        SRL_SRA = 3'b101,
        OR      = 3'b110,
        AND     = 3'b111
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational RV32I integer function unit.
// Ports:
//   a    [XLEN-1:0]  operand A (rs1)
//   b    [XLEN-1:0]  operand B (rs2 or immediate); only b[4:0] is used for shifts
//   op   [2:0]       operation select (funct3 encoding, see alu_op_e)
//   sign             SUB for ADD_SUB, arithmetic shift for SRL_SRA, ignored otherwise
//   y    [XLEN-1:0]  result
// -----------------------------------------------------------------------------
import alu_pkg::*;

module alu_comb (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            sign,
    output logic [XLEN-1:0] y
);

    logic [SHAMT_W-1:0] shamt_s;
    logic               lt_signed_s;
    logic               lt_unsigned_s;
    alu_op_e            op_s;

    assign op_s          = alu_op_e'(op);
    // Only the low five bits of b count as the shift amount, so b=32 means no shift.
    assign shamt_s       = b[SHAMT_W-1:0];
    assign lt_signed_s   = ($signed(a) < $signed(b));
    assign lt_unsigned_s = (a < b);

    // Select the operation result; the comparisons are zero-extended to XLEN.
    always_comb begin
        y = {XLEN{1'b0}};
        case (op_s)
            ADD_SUB: begin
                if (sign) begin
                    y = a - b;
                end else begin
                    y = a + b;
                end
            end
            SLL:     y = a << shamt_s;
            SLT:     y = {{(XLEN-1){1'b0}}, lt_signed_s};
            SLTU:    y = {{(XLEN-1){1'b0}}, lt_unsigned_s};
            XOR:     y = a ^ b;
            SRL_SRA: begin
                if (sign) begin
                    y = $unsigned($signed(a) >>> shamt_s);
                end else begin
                    y = a >> shamt_s;
                end
            end
            OR:      y = a | b;
            AND:     y = a & b;
            default: y = {XLEN{1'b0}};
        endcase
    end

endmodule : alu_comb

// File: rtl/rv32i_alu.sv
// -----------------------------------------------------------------------------
// rv32i_alu
// RV32I execute-stage ALU with a registered result. This block has a latency of
// one cycle, accepts one operation per cycle and has no backpressure. The result
// holds its value through cycles where in_valid is low.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears result and out_valid
//   in_valid   operands/op valid this cycle
//   a, b       operands [XLEN-1:0]
//   op         funct3 operation select [2:0]
//   sign       SUB / SRA modifier
//   result     registered result [XLEN-1:0]
//   out_valid  result valid
// -----------------------------------------------------------------------------
import alu_pkg::*;

module rv32i_alu #(
    parameter int unsigned XLEN = alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            sign,
    output logic [XLEN-1:0] result,
    output logic            out_valid
);

    logic [XLEN-1:0] y_s;
    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] result_q;
    logic            out_valid_d;
    logic            out_valid_q;

    alu_comb u_alu_comb (
        .a    (a),
        .b    (b),
        .op   (op),
        .sign (sign),
        .y    (y_s)
    );

    // Capture a new result only for valid operations; otherwise hold the last one.
    always_comb begin
        result_d    = result_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d = y_s;
        end else begin
            result_d = result_q;
        end
    end

    // Output registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= {XLEN{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule : rv32i_alu

// File: tb/tb_rv32i_alu.sv
// -----------------------------------------------------------------------------
// tb_rv32i_alu
// Self-checking bench for rv32i_alu. It applies a linear sequence of directed
// steps and then randomized operations. Each result is compared against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_rv32i_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sign;
    logic [31:0] result;
    logic        out_valid;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_result;

    rv32i_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .sign      (sign),
        .result    (result),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on 64-bit values, with shifts
    // expressed as multiplication and division by a power of two.
    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [2:0] mop, input logic msign);
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint p;
        longint r;
        int     sh;
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        sh = int'(ub % 64'sd32);
        p  = 64'sd1;
        for (int i = 0; i < sh; i++) p = p * 64'sd2;
        case (mop)
            3'd0:    r = msign ? (ua - ub) : (ua + ub);
            3'd1:    r = ua * p;
            3'd2:    r = (sa < sb) ? 64'sd1 : 64'sd0;
            3'd3:    r = (ua < ub) ? 64'sd1 : 64'sd0;
            3'd4:    r = longint'({32'd0, ma ^ mb});
            3'd5: begin
                if (!msign)        r = ua / p;
                else if (sa >= 0)  r = sa / p;
                else               r = (sa - (p - 64'sd1)) / p;  // floor division
            end
            3'd6:    r = longint'({32'd0, ma | mb});
            default: r = longint'({32'd0, ma & mb});
        endcase
        return r[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present one operation (or an idle cycle), then check the outputs 1ns after the edge.
    task automatic step(input string tag, input logic iv, input logic [31:0] ta,
                        input logic [31:0] tb_v, input logic [2:0] top, input logic ts);
        in_valid = iv;
        a        = ta;
        b        = tb_v;
        op       = top;
        sign     = ts;
        if (iv) exp_result = model(ta, tb_v, top, ts);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, iv});
        chk(tag, result, exp_result);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] edges [6];
        n_vec      = 0;
        n_err      = 0;
        exp_result = 32'd0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = 32'd0;
        b          = 32'd0;
        op         = 3'd0;
        sign       = 1'b0;
        edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h8000_0000;
        edges[3] = 32'h7FFF_FFFF; edges[4] = 32'h0000_0001; edges[5] = 32'h0000_001F;

        #1;
        chk("reset.result", result, 32'd0);
        chk("reset.valid", {31'd0, out_valid}, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add / sub with wrap-around
        step("add5_7",   1'b1, 32'd5,          32'd7, 3'd0, 1'b0);
        chk("add5_7.exp", result, 32'd12);
        step("sub5_7",   1'b1, 32'd5,          32'd7, 3'd0, 1'b1);
        chk("sub5_7.exp", result, 32'hFFFF_FFFE);
        step("sub10_7",  1'b1, 32'd10,         32'd7, 3'd0, 1'b1);
        step("addmax",   1'b1, 32'h7FFF_FFFF,  32'd1, 3'd0, 1'b0);
        chk("addmax.exp", result, 32'h8000_0000);
        step("submin",   1'b1, 32'h8000_0000,  32'd1, 3'd0, 1'b1);
        chk("submin.exp", result, 32'h7FFF_FFFF);
        // Shifts
        step("sll4",     1'b1, 32'hF,          32'd4, 3'd1, 1'b0);
        chk("sll4.exp", result, 32'hF0);
        step("sll6",     1'b1, 32'hF,          32'd6, 3'd1, 1'b0);
        step("srl4",     1'b1, 32'hF000_0000,  32'd4, 3'd5, 1'b0);
        chk("srl4.exp", result, 32'h0F00_0000);
        step("sra4",     1'b1, 32'hF000_0000,  32'd4, 3'd5, 1'b1);
        chk("sra4.exp", result, 32'hFF00_0000);
        step("sll_b24",  1'b1, 32'hF,          32'h24, 3'd1, 1'b0);
        chk("sll_b24.exp", result, 32'hF0);
        step("sll0",     1'b1, 32'h1234_5678,  32'd0, 3'd1, 1'b0);
        step("sra31",    1'b1, 32'h8000_0000,  32'd31, 3'd5, 1'b1);
        step("srl31",    1'b1, 32'h8000_0000,  32'd31, 3'd5, 1'b0);
        step("srl_b32",  1'b1, 32'hDEAD_BEEF,  32'd32, 3'd5, 1'b0);
        chk("srl_b32.exp", result, 32'hDEAD_BEEF);
        // Compares
        step("slt10_5",  1'b1, 32'd10,         32'd5, 3'd2, 1'b0);
        step("slt10_12", 1'b1, 32'd10,         32'd12, 3'd2, 1'b0);
        step("sltm1_0",  1'b1, 32'hFFFF_FFFF,  32'd0, 3'd2, 1'b0);
        chk("sltm1_0.exp", result, 32'd1);
        step("sltu10_12",1'b1, 32'd10,         32'd12, 3'd3, 1'b0);
        step("sltu10_m", 1'b1, 32'd10,         32'hFFFF_FFFF, 3'd3, 1'b0);
        step("sltum_0",  1'b1, 32'hFFFF_FFFF,  32'd0, 3'd3, 1'b0);
        chk("sltum_0.exp", result, 32'd0);
        step("sltu_eq",  1'b1, 32'd77,         32'd77, 3'd3, 1'b0);
        step("slt_eq",   1'b1, 32'h8000_0000,  32'h8000_0000, 3'd2, 1'b0);
        // Logic ops, sign is a don't-care
        for (int s = 0; s < 2; s++) begin
            step("xor", 1'b1, 32'hF, 32'h6, 3'd4, s[0]);
            chk("xor.exp", result, 32'h9);
            step("or",  1'b1, 32'hF, 32'h6, 3'd6, s[0]);
            chk("or.exp", result, 32'hF);
            step("and", 1'b1, 32'hF, 32'h6, 3'd7, s[0]);
            chk("and.exp", result, 32'h6);
            step("slt_s", 1'b1, 32'd3, 32'd9, 3'd2, s[0]);
        end
        // Idle cycles: out_valid drops and the result holds its last value
        step("idle1", 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd0, 1'b0);
        chk("idle1.hold", result, 32'd1);
        step("idle2", 1'b0, 32'h1, 32'h1, 3'd4, 1'b1);

        // Reset asserted mid-stream with a valid operation pending
        in_valid = 1'b1; a = 32'd1; b = 32'd2; op = 3'd0; sign = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        exp_result = 32'd0;
        chk("rst_mid.result", result, 32'd0);
        chk("rst_mid.valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold.result", result, 32'd0);
        chk("rst_hold.valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.valid", {31'd0, out_valid}, 32'd0);
        step("post_rst_add", 1'b1, 32'd5, 32'd7, 3'd0, 1'b0);
        chk("post_rst_add.exp", result, 32'd12);

        // Randomized back-to-back traffic with occasional idle cycles and edge operands
        for (int i = 0; i < 300; i++) begin
            ra = (i % 4 == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            rb = (i % 5 == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            step("rand", ($urandom_range(0, 7) != 0), ra, rb,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rv32i_alu

// File: doc/rv32i_alu.md
Name: rv32i_alu

Overview:
- RV32I integer ALU for the execute stage. It evaluates one register/immediate operation selected by a 3-bit funct3-style opcode plus a `sign` modifier bit.
- The result is registered: an operation presented with `in_valid` is available one clock later with `out_valid`.
- Feeds the writeback/forwarding path of the rv32i core.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported; shift amount is the low log2(XLEN)=5 bits of b.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op valid this cycle
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2 or immediate)
- op  input  3  operation select (RV32I funct3 encoding)
- sign  input  1  modifier: subtract for op=000, arithmetic shift for op=101; ignored otherwise
- result  output  XLEN  registered result
- out_valid  output  1  result valid

Behaviour:
- Reset: asserting rst_n=0 immediately forces result=0 and out_valid=0, independent of clk. This includes reset mid-operation; any in-flight op is discarded. After rst_n rises, the first accepted op appears one cycle later.
- Latency: exactly 1 cycle, fully pipelined, one op per cycle, no stall/backpressure.
- On each rising clk edge:
  - out_valid <= in_valid.
  - If in_valid=1, result <= f(a, b, op, sign).
  - If in_valid=0, result holds its previous value.
- Operation table (all arithmetic modulo 2^XLEN, no flags, no exceptions):
  - 000: sign=0 → a+b; sign=1 → a−b (two's complement, wraps silently).
  - 001 SLL: a << b[4:0], zero fill; b[31:5] ignored.
  - 010 SLT: 1 if signed(a) < signed(b), else 0; zero-extended to XLEN.
  - 011 SLTU: 1 if unsigned(a) < unsigned(b), else 0.
  - 100 XOR: a ^ b.
  - 101: sign=0 → SRL (logical right shift, zero fill); sign=1 → SRA (arithmetic right shift, a[31] replicated). Shift amount is b[4:0].
  - 110 OR: a | b.
  - 111 AND: a & b.
- Boundaries:
  - Shift by 0 returns a unchanged.
  - Shift by 31 is legal.
  - b=32 shifts by 0, because only b[4:0] is used.
  - SLT/SLTU with a==b returns 0.
  - 0x80000000 − 1 = 0x7FFFFFFF; 0x7FFFFFFF + 1 = 0x80000000, with no overflow indication.
- `sign` is don't-care for ops other than 000 and 101. Those ops produce identical results for sign=0 and sign=1.
- No X-propagation from unused inputs: result depends only on the fields listed above.

Decomposition:
- Package `alu_pkg`:
  - enum `alu_op_e`: ADD_SUB=3'b000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND=111.
  - constants XLEN=32 and SHAMT_W=5.
- Sub-module `alu_comb`:
  - purely combinational function unit with ports a, b, op, sign, y.
  - rv32i_alu instantiates it and adds only the in_valid/out_valid/result registers with async active-low reset.
  - The bench may also target alu_comb directly.

Test Plan:
- Reset: rst_n=0 mid-stream with in_valid=1 → result=0 and out_valid=0 immediately. After release, op ADD a=5 b=7 → result=12 one cycle later.
- Add/sub: 5+7 (sign=0) → 12. 5−7 (sign=1) → 0xFFFFFFFE. 10−7 → 3. 0x7FFFFFFF+1 → 0x80000000.
- Shifts:
  - SLL 0xF<<4 → 0xF0; 0xF<<6 → 0x3C0.
  - SRL 0xF0000000>>4 → 0x0F000000; SRA same inputs → 0xFF000000.
  - SLL with b=0x24 → shift by 4.
- Compares:
  - SLT 10<5 → 0; 10<12 → 1; −1<0 → 1.
  - SLTU 10<12 → 1; 10<0xFFFFFFFF → 1; 0xFFFFFFFF<0 → 0; equal operands → 0.
- Logic with a=0xF, b=0x6: XOR → 0x9, OR → 0xF, AND → 0x6. Repeat each with sign=1 → identical results.
- Pipelining: back-to-back ops on consecutive cycles → results in order, one cycle each. A cycle with in_valid=0 → out_valid=0 and result holds its last value.
